// File: rtl/bram_stream_fifo_ctrl.sv
// Circular FIFO controller over a single-port synchronous-read RAM with valid/ready streams.
// Optional macro BRAM_STREAM_FIFO_HWM_EN builds the hwm high-water-mark register.
module bram_stream_fifo_ctrl #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DEPTH_LOG2:0]   hwm
);

    typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;

    localparam logic [DEPTH_LOG2:0]   RING_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    grant_e                last_grant;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   mem_level;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  capture_pending;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_tail;
    logic                  want_wr;
    logic                  want_rd;
    logic                  wr_grant;
    logic                  rd_grant;
    logic                  pop;

    // Round-robin arbiter; a read needs a free buffer slot counting the capture in flight.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        want_wr  = in_valid && (mem_level != RING_WORDS) && !reset;
        want_rd  = (mem_level != '0) && ((buf_cnt + {1'b0, capture_pending}) < 2'd2) && !reset;
        if (want_wr && want_rd) begin
            if (last_grant == GRANT_RD) wr_grant = 1'b1;
            else                        rd_grant = 1'b1;
        end else begin
            wr_grant = want_wr;
            rd_grant = want_rd;
        end
    end

    always_comb begin
        in_ready  = wr_grant;
        mem_we    = wr_grant;
        mem_oe    = rd_grant || capture_pending;
        mem_wdata = wr_grant ? in_data : '0;
        mem_addr  = '0;
        if (wr_grant)      mem_addr[DEPTH_LOG2-1:0] = wr_ptr;
        else if (rd_grant) mem_addr[DEPTH_LOG2-1:0] = rd_ptr;
    end

    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count;
        if (wr_grant && !pop)      count_next = count + LEVEL_ONE;
        else if (!wr_grant && pop) count_next = count - LEVEL_ONE;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            last_grant      <= GRANT_RD;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            mem_level       <= '0;
            count           <= '0;
            capture_pending <= 1'b0;
            buf_cnt         <= 2'd0;
            buf_tail        <= '0;
            out_data        <= '0;
        end else begin
            capture_pending <= rd_grant;
            count           <= count_next;
            if (wr_grant) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                mem_level  <= mem_level + LEVEL_ONE;
                last_grant <= GRANT_WR;
            end else if (rd_grant) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                mem_level  <= mem_level - LEVEL_ONE;
                last_grant <= GRANT_RD;
            end
            // Capture takes the word the RAM registered on the previous edge.
            if (capture_pending && pop) begin
                if (buf_cnt == 2'd2) begin
                    out_data <= buf_tail;
                    buf_tail <= mem_rdata;
                end else begin
                    out_data <= mem_rdata;
                end
            end else if (capture_pending) begin
                if (buf_cnt == 2'd0) out_data <= mem_rdata;
                else                 buf_tail <= mem_rdata;
                buf_cnt <= buf_cnt + 2'd1;
            end else if (pop) begin
                out_data <= buf_tail;
                buf_cnt  <= buf_cnt - 2'd1;
            end
        end
    end

`ifdef BRAM_STREAM_FIFO_HWM_EN
    always_ff @(posedge clk) begin
        if (reset)                  hwm <= '0;
        else if (count_next > hwm)  hwm <= count_next;
    end
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Bench for bram_stream_fifo_ctrl: a full-size instance and a 16-word ring instance, each with a RAM model,
// checked against a word-queue scoreboard. Honours BRAM_STREAM_FIFO_HWM_EN for the hwm expectation.
module tb_bram_stream_fifo_ctrl;

    localparam int AW  = 23;
    localparam int DW  = 16;
    localparam int DL0 = 16;
    localparam int DL1 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid [2];
    logic          in_ready [2];
    logic          out_valid[2];
    logic          out_ready[2];
    logic          mem_we   [2];
    logic          mem_oe   [2];
    logic [DW-1:0] in_data  [2];
    logic [DW-1:0] out_data [2];
    logic [DW-1:0] mem_wdata[2];
    logic [DW-1:0] mem_rdata[2];
    logic [AW-1:0] mem_addr [2];
    logic [DL0:0]  count0, hwm0;
    logic [DL1:0]  count1, hwm1;

    bram_stream_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .count(count0), .mem_we(mem_we[0]), .mem_oe(mem_oe[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .hwm(hwm0)
    );

    bram_stream_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL1)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .count(count1), .mem_we(mem_we[1]), .mem_oe(mem_oe[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .hwm(hwm1)
    );

    // Single-port synchronous-read RAMs; a write cycle leaves the registered read data alone.
    logic [DW-1:0] ram0 [0:(1<<DL0)-1];
    logic [DW-1:0] ram1 [0:(1<<DL1)-1];
    logic [DW-1:0] ram_q0, ram_q1;

    always @(posedge clk) begin
        if (mem_we[0])      ram0[mem_addr[0][DL0-1:0]] <= mem_wdata[0];
        else if (mem_oe[0]) ram_q0 <= ram0[mem_addr[0][DL0-1:0]];
    end
    always @(posedge clk) begin
        if (mem_we[1])      ram1[mem_addr[1][DL1-1:0]] <= mem_wdata[1];
        else if (mem_oe[1]) ram_q1 <= ram1[mem_addr[1][DL1-1:0]];
    end
    assign mem_rdata[0] = mem_oe[0] ? ram_q0 : 16'hDEAD;
    assign mem_rdata[1] = mem_oe[1] ? ram_q1 : 16'hDEAD;

    int checks   = 0;
    int failures = 0;

    // Reference model: words pushed and not yet popped, plus counters.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int unsigned   m_count[2];
    int unsigned   m_max  [2];
    int unsigned   m_wr_n [2];
    int unsigned   m_pops [2];

    logic [31:0] smp_ir[2], smp_ov[2], smp_od[2], smp_we[2], smp_oe[2];
    logic [31:0] smp_addr[2], smp_wdata[2], smp_cnt[2], smp_hwm[2];

    int sent, found, wrap_seen, prev_addr, pops_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int k);
        int unsigned ring;
        logic [31:0] front;
        int          qsize;
        bit          push, pop;
        ring          = (k == 0) ? (32'd1 << DL0) : (32'd1 << DL1);
        smp_ir[k]     = 32'(in_ready[k]);
        smp_ov[k]     = 32'(out_valid[k]);
        smp_od[k]     = 32'(out_data[k]);
        smp_we[k]     = 32'(mem_we[k]);
        smp_oe[k]     = 32'(mem_oe[k]);
        smp_addr[k]   = 32'(mem_addr[k]);
        smp_wdata[k]  = 32'(mem_wdata[k]);
        smp_cnt[k]    = (k == 0) ? 32'(count0) : 32'(count1);
        smp_hwm[k]    = (k == 0) ? 32'(hwm0) : 32'(hwm1);
        if (reset) begin
            m_count[k] = 0;
            m_max[k]   = 0;
            m_wr_n[k]  = 0;
            if (k == 0) q0.delete();
            else        q1.delete();
            return;
        end
        check($sformatf("count[%0d]", k), smp_cnt[k], m_count[k]);
`ifdef BRAM_STREAM_FIFO_HWM_EN
        check($sformatf("hwm[%0d]", k), smp_hwm[k], m_max[k]);
`else
        check($sformatf("hwm[%0d]", k), smp_hwm[k], 0);
`endif
        check($sformatf("addr_hi[%0d]", k), smp_addr[k] / ring, 0);
        if (m_count[k] == 0) begin
            check($sformatf("empty_ov[%0d]", k), smp_ov[k], 0);
            check($sformatf("empty_oe[%0d]", k), smp_oe[k], 0);
        end
        if (m_count[k] >= ring + 2) check($sformatf("over_ir[%0d]", k), smp_ir[k], 0);
        if (!in_valid[k])           check($sformatf("idle_ir[%0d]", k), smp_ir[k], 0);
        push = in_valid[k] && in_ready[k];
        pop  = out_valid[k] && out_ready[k];
        if (push) begin
            check($sformatf("wr_we[%0d]", k), smp_we[k], 1);
            check($sformatf("wr_addr[%0d]", k), smp_addr[k], m_wr_n[k] % ring);
            check($sformatf("wr_data[%0d]", k), smp_wdata[k], 32'(in_data[k]));
        end
        qsize = (k == 0) ? q0.size() : q1.size();
        if (out_valid[k]) begin
            check($sformatf("ov_has_word[%0d]", k), 32'(qsize > 0), 1);
            if (qsize > 0) begin
                front = (k == 0) ? 32'(q0[0]) : 32'(q1[0]);
                check($sformatf("out_data[%0d]", k), smp_od[k], front);
            end
        end
        if (push) begin
            if (k == 0) q0.push_back(in_data[0]);
            else        q1.push_back(in_data[1]);
            m_wr_n[k]++;
            m_count[k]++;
        end
        if (pop && qsize > 0) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            m_pops[k]++;
            m_count[k]--;
        end
        if (m_count[k] > m_max[k]) m_max[k] = m_count[k];
    endtask

    task automatic cycle();
        @(negedge clk);
        sample(0);
        sample(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input int k, input int budget);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        for (int i = 0; i < budget && m_count[k] != 0; i++) cycle();
        cycle();
        check($sformatf("drained[%0d]", k), smp_cnt[k], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = '0;
            m_pops[k]    = 0;
        end
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                check("idle_in_ready", smp_ir[k], 0);
                check("idle_out_valid", smp_ov[k], 0);
                check("idle_mem_we", smp_we[k], 0);
                check("idle_mem_oe", smp_oe[k], 0);
                check("idle_count", smp_cnt[k], 0);
            end
            if (i == 0) begin
                check("rst_out_data", smp_od[0], 0);
                check("rst_mem_addr", smp_addr[0], 0);
                check("rst_mem_wdata", smp_wdata[0], 0);
                check("rst_hwm", smp_hwm[0], 0);
            end
        end

        // Single word latency.
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h1234;
        cycle();
        check("w1_we", smp_we[0], 1);
        check("w1_addr", smp_addr[0], 0);
        check("w1_wdata", smp_wdata[0], 32'h1234);
        check("w1_in_ready", smp_ir[0], 1);
        in_valid[0] = 1'b0;
        cycle();
        check("r1_oe", smp_oe[0], 1);
        check("r1_we", smp_we[0], 0);
        check("r1_addr", smp_addr[0], 0);
        check("r1_ov", smp_ov[0], 0);
        cycle();
        check("c1_oe", smp_oe[0], 1);
        check("c1_ov", smp_ov[0], 0);
        cycle();
        check("v1_ov", smp_ov[0], 1);
        check("v1_data", smp_od[0], 32'h1234);
        cycle();
        check("v1_count_after", smp_cnt[0], 0);
        check("v1_ov_after", smp_ov[0], 0);

        // Continuous stream: writes and reads alternate.
        do_reset();
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0000;
        sent      = 0;
        pops_base = int'(m_pops[0]);
        for (int i = 0; i < 1200 && sent < 256; i++) begin
            cycle();
            check("stream_alternate", smp_we[0], 32'(i % 2 == 0));
            if (smp_ir[0] == 1) begin
                sent++;
                in_data[0] = 16'(sent);
            end
        end
        check("stream_sent", sent, 256);
        drain(0, 50);
        check("stream_received", m_pops[0] - pops_base, 256);

        // Small ring fill to full, then drain.
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 16'($urandom);
        sent      = 0;
        wrap_seen = 0;
        prev_addr = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (smp_we[1] == 1) begin
                if (prev_addr == 15 && smp_addr[1] == 0) wrap_seen = 1;
                prev_addr = int'(smp_addr[1]);
            end
            if (smp_ir[1] == 1) begin
                sent++;
                in_data[1] = 16'($urandom);
            end
        end
        check("full_accepted", sent, 18);
        check("full_count", smp_cnt[1], 18);
        check("full_in_ready", smp_ir[1], 0);
        check("full_wrap", wrap_seen, 1);
        pops_base = int'(m_pops[1]);
        drain(1, 100);
        check("full_drained_words", m_pops[1] - pops_base, 18);

        // Randomised traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            in_valid[0]  = ($urandom_range(0, 3) != 0);
            out_ready[0] = ($urandom_range(0, 1) != 0);
            in_valid[1]  = ($urandom_range(0, 3) != 0);
            out_ready[1] = ($urandom_range(0, 3) == 0);
            cycle();
            for (int k = 0; k < 2; k++)
                if (smp_ir[k] == 1) in_data[k] = 16'($urandom);
        end
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        drain(0, 2000);
        drain(1, 200);

        // Reset arriving the cycle after a read issue.
        do_reset();
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h5A5A;
        cycle();
        in_valid[0] = 1'b0;
        cycle();
        check("pre_rst_issue_oe", smp_oe[0], 1);
        check("pre_rst_issue_we", smp_we[0], 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("mid_rst_oe", smp_oe[0], 0);
        check("mid_rst_ov", smp_ov[0], 0);
        check("mid_rst_count", smp_cnt[0], 0);
        cycle();
        check("mid_rst_ov_later", smp_ov[0], 0);
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'hBEEF;
        cycle();
        check("beef_we", smp_we[0], 1);
        check("beef_addr", smp_addr[0], 0);
        in_valid[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            cycle();
            if (smp_ov[0] == 1) begin
                found = 1;
                check("beef_data", smp_od[0], 32'hBEEF);
            end
        end
        check("beef_seen", found, 1);

        // High-water mark after seven words pushed and drained.
        do_reset();
        in_valid[0] = 1'b1;
        in_data[0]  = 16'($urandom);
        sent = 0;
        for (int i = 0; i < 20 && sent < 7; i++) begin
            cycle();
            if (smp_ir[0] == 1) begin
                sent++;
                in_data[0] = 16'($urandom);
            end
        end
        in_valid[0] = 1'b0;
        check("hwm_pushed", sent, 7);
        drain(0, 50);
`ifdef BRAM_STREAM_FIFO_HWM_EN
        check("hwm_final", smp_hwm[0], 7);
`else
        check("hwm_final", smp_hwm[0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
